// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle: datapath request/response and data-memory port.
//   req_*      : datapath request (valid, write, funct3, addr, store data)
//   stall/done : datapath hold and one-cycle completion pulse
//   fault      : completion with error (misaligned, illegal funct3, timeout)
//   rdata      : extended load result
//   mem_*      : word-aligned request/ready data-memory port
// modport slave  : the load/store unit itself
// modport master : the environment (datapath plus memory)
interface load_store_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_write;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             stall;
    logic             done;
    logic             fault;
    logic [WIDTH-1:0] rdata;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [3:0]       mem_be;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output stall, done, fault, rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  stall, done, fault, rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the core datapath and a
// variable-latency data memory. One access per request; the datapath is
// stalled until a one-cycle done pulse. Misaligned or illegal requests
// complete with fault and no memory access; a memory that does not answer
// within TIMEOUT cycles is abandoned with fault.
// Ports:
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : load_store_unit_if slave (request, response, memory port)
module load_store_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic              clk,
    input logic              reset_n,
    load_store_unit_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]       lane_q, lane_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic             illegal_c;
    logic             misalign_c;
    logic [3:0]       st_be_c;
    logic [WIDTH-1:0] st_wdata_c;
    logic [WIDTH-1:0] ld_shift_c;
    logic [7:0]       ld_byte_c;
    logic [15:0]      ld_half_c;
    logic [WIDTH-1:0] ld_data_c;

    // Request decode: legality, alignment and store lane placement.
    always_comb begin
        illegal_c  = 1'b0;
        misalign_c = 1'b0;
        st_be_c    = 4'b0000;
        st_wdata_c = '0;
        if (bus.req_write) begin
            illegal_c = (bus.req_funct3 >= 3'd3);
        end else begin
            illegal_c = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
        end
        unique case (bus.req_funct3[1:0])
            2'b01:   misalign_c = bus.req_addr[0];
            2'b10:   misalign_c = (bus.req_addr[1:0] != 2'b00);
            default: misalign_c = 1'b0;
        endcase
        unique case (bus.req_funct3[1:0])
            2'b00: begin
                st_be_c    = 4'b0001 << bus.req_addr[1:0];
                st_wdata_c = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_be_c    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata_c = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                st_be_c    = 4'b1111;
                st_wdata_c = bus.req_wdata;
            end
        endcase
    end

    // Load extraction from the returned word using the latched lane/funct3.
    always_comb begin
        ld_shift_c = bus.mem_rdata >> {lane_q, 3'b000};
        ld_byte_c  = ld_shift_c[7:0];
        ld_half_c  = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        unique case (funct3_q)
            3'b000:  ld_data_c = {{(WIDTH-8){ld_byte_c[7]}}, ld_byte_c};
            3'b001:  ld_data_c = {{(WIDTH-16){ld_half_c[15]}}, ld_half_c};
            3'b100:  ld_data_c = {{(WIDTH-8){1'b0}}, ld_byte_c};
            3'b101:  ld_data_c = {{(WIDTH-16){1'b0}}, ld_half_c};
            default: ld_data_c = bus.mem_rdata;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        lane_d      = lane_q;
        funct3_d    = funct3_q;
        done_d      = 1'b0;
        fault_d     = fault_q;
        rdata_d     = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                fault_d = 1'b0;
                if (bus.req_valid) begin
                    if (illegal_c || misalign_c) begin
                        fault_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_write;
                        mem_addr_d  = {bus.req_addr[WIDTH-1:2], 2'b00};
                        mem_be_d    = bus.req_write ? st_be_c : 4'b0000;
                        mem_wdata_d = bus.req_write ? st_wdata_c : '0;
                        lane_d      = bus.req_addr[1:0];
                        funct3_d    = bus.req_funct3;
                        cnt_d       = '0;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = ld_data_c;
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Last allowed WAIT cycle passed without a response.
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                fault_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            lane_q      <= 2'b00;
            funct3_q    <= 3'b000;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            lane_q      <= lane_d;
            funct3_q    <= funct3_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
        end
    end

    // Stall is combinational so the datapath holds in the accepting cycle.
    assign bus.stall     = bus.req_valid && (state_q != S_DONE);
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses against a behavioural model of the access rules.
module tb_load_store_unit;

    localparam int unsigned TIMEOUT = 16;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;
    logic [31:0] model_rdata;

    load_store_unit_if #(.WIDTH(32)) bus ();

    load_store_unit #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Request completes with fault before touching memory.
    function automatic bit pre_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        bit illegal;
        bit mis;
        sz      = f3 % 4;
        illegal = wr ? (f3 > 2) : (f3 == 3 || f3 > 5);
        mis     = (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
        return illegal || mis;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        case (f3 % 4)
            0:       return 4'(1 << (a % 4));
            1:       return 4'(3 << (a % 4));
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3 % 4)
            0:       return (d % 256) * 32'h0101_0101;
            1:       return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (a % 4))) % 256;
        h = (w >> (16 * ((a / 2) % 2))) % 65536;
        case (f3)
            3'd0:    return b + ((b >= 128) ? 32'hFFFF_FF00 : 32'h0);
            3'd1:    return h + ((h >= 32768) ? 32'hFFFF_0000 : 32'h0);
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // One access starting at a negedge with the unit idle. lat = number of
    // WAIT cycles before mem_ready (>= TIMEOUT means never). Returns at the
    // negedge of the following idle cycle.
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, input logic [31:0] word,
                          input bit drop);
        bit pre;
        bit seen_done;
        int exp_req;
        int exp_done;
        int cyc;
        int reqs;
        int stalls;
        pre      = pre_fault(wr, f3, a);
        exp_req  = pre ? 0 : ((lat >= int'(TIMEOUT)) ? int'(TIMEOUT) : lat + 1);
        exp_done = pre ? 1 : ((lat >= int'(TIMEOUT)) ? int'(TIMEOUT) + 1 : lat + 2);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.mem_ready  = 1'($urandom_range(0, 1));
        bus.mem_rdata  = $urandom;
        #1;
        cyc = 0; reqs = 0; stalls = 0; seen_done = 1'b0;
        if (bus.stall) stalls++;
        while (!seen_done && cyc < int'(TIMEOUT) + 8) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                seen_done = 1'b1;
                if (!wr && !pre && lat < int'(TIMEOUT)) model_rdata = model_load(f3, a, word);
                chk("done_cycle", 32'(cyc), 32'(exp_done));
                chk("fault", 32'(bus.fault), 32'(pre || lat >= int'(TIMEOUT)));
                chk("rdata", bus.rdata, model_rdata);
                chk("stall_at_done", 32'(bus.stall), 32'd0);
                chk("mem_req_at_done", 32'(bus.mem_req), 32'd0);
                chk("mem_req_cycles", 32'(reqs), 32'(exp_req));
                if (!drop) chk("stall_cycles", 32'(stalls), 32'(exp_done));
                bus.req_valid = 1'b0;
                bus.mem_ready = 1'($urandom_range(0, 1));
            end else begin
                if (bus.stall) stalls++;
                if (bus.mem_req) begin
                    if (reqs == 0) begin
                        chk("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
                        chk("mem_we", 32'(bus.mem_we), 32'(wr));
                        chk("mem_be", 32'(bus.mem_be), wr ? 32'(model_be(f3, a)) : 32'd0);
                        if (wr) chk("mem_wdata", bus.mem_wdata, model_wdata(f3, wd));
                    end
                    bus.mem_ready = (reqs == lat);
                    bus.mem_rdata = (reqs == lat) ? word : $urandom;
                    reqs++;
                end else begin
                    bus.mem_ready = 1'($urandom_range(0, 1));
                    bus.mem_rdata = $urandom;
                end
                if (drop && cyc == 1) bus.req_valid = 1'b0;
            end
        end
        chk("done_seen", 32'(seen_done), 32'd1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_rdata    = 32'h0;
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'h0;
        #2;
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        access(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
        chk("lw_value", bus.rdata, 32'hDEAD_BEEF);
        access(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_1234, 1'b0);
        chk("lb_value", bus.rdata, 32'hFFFF_FF80);
        access(1'b0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF_1234, 1'b0);
        chk("lbu_value", bus.rdata, 32'h0000_0080);
        access(1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF_1234, 1'b0);
        chk("lh_value", bus.rdata, 32'hFFFF_80FF);
        access(1'b1, 3'b000, 32'h201, 32'h0000_00AB, 0, 32'h0, 1'b0);
        access(1'b1, 3'b001, 32'h202, 32'h0000_5678, 1, 32'h0, 1'b0);
        access(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 1'b0);
        access(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b0);
        chk("fault_keeps_rdata", bus.rdata, 32'hFFFF_80FF);
        access(1'b0, 3'b010, 32'h104, 32'h0, int'(TIMEOUT) + 4, 32'h0, 1'b0);
        access(1'b0, 3'b010, 32'h108, 32'h0, int'(TIMEOUT) - 1, 32'h1357_9BDF, 1'b0);
        access(1'b1, 3'b010, 32'h300, 32'h1122_3344, 1, 32'h0, 1'b1);
        access(1'b0, 3'b010, 32'h300, 32'h0, 2, 32'h1122_3344, 1'b1);

        // Reset asserted in the middle of WAIT.
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h400;
        bus.req_wdata  = 32'hCAFE_F00D;
        bus.mem_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("midrst_mem_addr", bus.mem_addr, 32'h0);
        chk("midrst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("midrst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("midrst_rdata", bus.rdata, 32'h0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_fault", 32'(bus.fault), 32'd0);
        chk("midrst_stall", 32'(bus.stall), 32'd1);
        model_rdata = 32'h0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        // Randomized accesses.
        for (int i = 0; i < 60; i++) begin
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] w;
            int          r;
            int          lat;
            bit          drop;
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            wd   = $urandom;
            w    = $urandom;
            r    = int'($urandom_range(0, 11));
            lat  = (r == 11) ? int'(TIMEOUT) + 2 : r % 5;
            drop = ($urandom_range(0, 3) == 0);
            access(wr, f3, a, wd, lat, w, drop);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
